counter_ctrl: RTL

Front-end control stage for the 24-bit up/down display counter. It takes four raw, bouncing push-buttons and produces the counter's control inputs:
- run enable
- rate tick
- direction
- free-run/half-range mode
- synchronous clear pulse

All outputs are registered. Each output drives the same-named counter input directly.

---
 rtl/counter_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/counter_ctrl.sv
// Button front end for the display counter: sync, debounce and press detection on four buttons, run FSM, rate prescaler.
// Latency: raw edge sampled at edge k reaches the outputs at edge k+DB_CYCLES+3; no backpressure, all outputs registered.
module counter_ctrl #(
    parameter int DIV       = 50000,
    parameter int DB_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_run,
    input  logic btn_dir,
    input  logic btn_mode,
    input  logic btn_clr,
    output logic enable1,
    output logic enable2,
    output logic updown,
    output logic freerun,
    output logic count_clr
);

    localparam logic [23:0] DB_MAX  = 24'(DB_CYCLES - 1);
    localparam logic [23:0] PRE_MAX = 24'(DIV - 1);
    localparam int B_RUN  = 0;
    localparam int B_DIR  = 1;
    localparam int B_MODE = 2;
    localparam int B_CLR  = 3;

    typedef enum logic {ST_STOP, ST_RUN} run_state_t;

    logic [3:0]  sync1_q, sync1_d;
    logic [3:0]  sync2_q, sync2_d;
    logic [3:0]  stable_q, stable_d;
    logic [3:0]  stable_prev_q, stable_prev_d;
    logic [3:0]  press_q, press_d;
    logic [23:0] db_cnt_q [4];
    logic [23:0] db_cnt_d [4];
    logic [23:0] pre_q, pre_d;
    run_state_t  state_q, state_d;
    logic        enable1_q, enable1_d;
    logic        enable2_q, enable2_d;
    logic        updown_q, updown_d;
    logic        freerun_q, freerun_d;
    logic        count_clr_q, count_clr_d;

    // Debounce: a level change is accepted only after DB_CYCLES consecutive differing samples.
    always_comb begin
        sync1_d       = {btn_clr, btn_mode, btn_dir, btn_run};
        sync2_d       = sync1_q;
        stable_d      = stable_q;
        stable_prev_d = stable_q;
        press_d       = stable_q & ~stable_prev_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_MAX) begin
                stable_d[i] = sync2_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 24'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pre_d       = pre_q;
        enable2_d   = 1'b0;
        if (press_q[B_RUN]) begin
            state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
        end
        // Prescaler restarts from 0 on every run entry and on every clear.
        if (press_q[B_CLR] || press_q[B_RUN] || (state_q == ST_STOP)) begin
            pre_d = '0;
        end else if (pre_q == PRE_MAX) begin
            pre_d     = '0;
            enable2_d = 1'b1;
        end else begin
            pre_d = pre_q + 24'd1;
        end
        enable1_d   = press_q[B_CLR] | (state_d == ST_RUN);
        updown_d    = updown_q ^ press_q[B_DIR];
        freerun_d   = freerun_q ^ press_q[B_MODE];
        count_clr_d = press_q[B_CLR];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            press_q       <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
            pre_q       <= '0;
            state_q     <= ST_STOP;
            enable1_q   <= 1'b0;
            enable2_q   <= 1'b0;
            updown_q    <= 1'b1;
            freerun_q   <= 1'b1;
            count_clr_q <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            press_q       <= press_d;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            pre_q       <= pre_d;
            state_q     <= state_d;
            enable1_q   <= enable1_d;
            enable2_q   <= enable2_d;
            updown_q    <= updown_d;
            freerun_q   <= freerun_d;
            count_clr_q <= count_clr_d;
        end
    end

    assign enable1   = enable1_q;
    assign enable2   = enable2_q;
    assign updown    = updown_q;
    assign freerun   = freerun_q;
    assign count_clr = count_clr_q;

endmodule
